keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Drives the column side of the 4x4 row-scanned keypad matrix: samples the active-low `keypadRow` strobe and returns `keypadCol` as a physical key would.
- Takes key-press commands over a valid/ready handshake and queues them in a small FIFO.
- Replays each key as a timed press (hold), then a release (gap).
- Used as the on-chip stimulus source for the keypad scanner and game logic in autoplay/demo mode and in system benches.

Parameters:
- HOLD_CYCLES, 24, clk_div cycles a key is held pressed (1..255; default = two full scans at 3 cycles/row).
- GAP_CYCLES, 12, clk_div cycles of release after each press (1..255).
- FIFO_DEPTH, 4, command queue depth (power of 2, >= 2).

Ports:
- clk_div  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- keypadRow  in  4  active-low row strobe from the scanner.
- cmd_valid  in  1  command present.
- cmd_key  in  4  key code 0x0..0xF.
- cmd_ready  out  1  command can be accepted.
- keypadCol  out  4  active-low column return to the scanner.
- key_active  out  1  a key is currently held.
- pressed_key  out  4  code of the key being replayed.
- key_done  out  1  one-cycle pulse when a press+gap sequence completes.
- fifo_count  out  3  queued commands; width is clog2(FIFO_DEPTH)+1.

Behaviour:
- Reset values (registered outputs and state):
  - state=IDLE, FIFO empty, counters 0.
  - key_active=0, pressed_key=0, key_done=0, fifo_count=0.
  - keypadCol=4'b1111.
  - cmd_ready=0 while reset is high; commands are ignored during reset.
- Handshake:
  - cmd_ready = !reset && fifo_count != FIFO_DEPTH.
  - A push occurs on an edge where cmd_valid && cmd_ready.
  - When the FIFO is full, ready is low even if a pop happens the same cycle (no pass-through).
  - Push and pop in the same cycle: count unchanged, order preserved.
- Key map (code -> row,col), which must match the scanner:
  - row 1110: col 1110=7, 1101=4, 1011=1, 0111=0.
  - row 1101: col 1110=8, 1101=5, 1011=2, 0111=A.
  - row 1011: col 1110=9, 1101=6, 1011=3, 0111=B.
  - row 0111: col 1110=C, 1101=D, 1011=E, 0111=F.
- keypadCol is the only combinational path (row in -> col out), so the scanner sees a consistent row/col pair in the same cycle.
  - keypadCol = the mapped column pattern if key_active && keypadRow equals the mapped row of pressed_key.
  - Otherwise 4'b1111, including any keypadRow that is not exactly one low bit (1111, 0000, 1100, ...).
- FSM:
  - IDLE: if FIFO non-empty, pop head into pressed_key, set key_active=1, clear counter, go to PRESS. Otherwise stay.
  - PRESS: counter increments each cycle. When counter==HOLD_CYCLES-1: key_active=0, clear counter, go to GAP. key_active is therefore high for exactly HOLD_CYCLES cycles.
  - GAP: keypadCol=1111. When counter==GAP_CYCLES-1: assert key_done for one cycle, go to IDLE.
- Latency:
  - A push at edge N into an empty FIFO while IDLE gives key_active=1 after edge N+1.
  - Back-to-back queued keys repeat with period HOLD_CYCLES+GAP_CYCLES+1 (one IDLE cycle between sequences).
- pressed_key holds its last value after release; it changes only on a pop.
- Counters are 8-bit and never wrap, because parameters are at most 255.
- Reset mid-operation (PRESS or GAP): the next cycle is IDLE with FIFO flushed, key_active=0, keypadCol=1111, and no key_done pulse.
- cmd_valid with cmd_ready low: nothing is stored, and cmd_key may change freely.

Test Plan:
- Reset, push 5, scanner rows cycling -> key_active rises one cycle after the push.
  - keypadCol=1101 only when keypadRow=1101; 1111 on all other rows.
  - key_active high 24 cycles, then 12 gap cycles, then a single key_done pulse; pressed_key=5.
- Push 0, then F, then A -> col 0111 on row 1110, then on row 0111, then on row 1101. Sequences start 37 cycles apart.
- Idle and empty, cmd_valid held for keys 1..6 on consecutive cycles -> keys 1..5 accepted, fifo_count reaches 4, cmd_ready=0.
  - Key 6 is accepted one cycle after key 1's sequence pops key 2.
  - Replay order is 1,2,3,4,5,6.
- Key 9 active, reset pulsed for 1 cycle after 10 PRESS cycles, with 2 entries queued -> keypadCol=1111, key_active=0, fifo_count=0, no key_done, cmd_ready=1 after reset drops.
- Key 3 active, keypadRow driven to 1111, 0000, then 1001 -> keypadCol=1111 in each case; with keypadRow=1011, keypadCol=1011.
- Closed loop with the scanner at 3 cycles/row, pushing 4 then 7 -> the scanner's key buffer reads 4, then 7, within 12 cycles of each press start.

Source files
------------

// File: rtl/keypad_emulator.sv
// Keypad emulator: replays queued key codes as timed presses on the column
// side of a 4x4 active-low row-scanned keypad matrix.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 24,
  parameter int GAP_CYCLES  = 12,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_div,
  input  logic                          reset,
  input  logic [3:0]                    keypadRow,
  input  logic                          cmd_valid,
  input  logic [3:0]                    cmd_key,
  output logic                          cmd_ready,
  output logic [3:0]                    keypadCol,
  output logic                          key_active,
  output logic [3:0]                    pressed_key,
  output logic                          key_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            active_q, active_d;
  logic [3:0]      key_q, key_d;
  logic            done_q, done_d;

  logic [3:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push, pop;
  logic [7:0]      rowcol;

  // Key code to {row strobe, column return}; must agree with the scanner's layout.
  function automatic logic [7:0] key_map(input logic [3:0] k);
    case (k)
      4'h7: key_map = {4'b1110, 4'b1110};
      4'h4: key_map = {4'b1110, 4'b1101};
      4'h1: key_map = {4'b1110, 4'b1011};
      4'h0: key_map = {4'b1110, 4'b0111};
      4'h8: key_map = {4'b1101, 4'b1110};
      4'h5: key_map = {4'b1101, 4'b1101};
      4'h2: key_map = {4'b1101, 4'b1011};
      4'hA: key_map = {4'b1101, 4'b0111};
      4'h9: key_map = {4'b1011, 4'b1110};
      4'h6: key_map = {4'b1011, 4'b1101};
      4'h3: key_map = {4'b1011, 4'b1011};
      4'hB: key_map = {4'b1011, 4'b0111};
      4'hC: key_map = {4'b0111, 4'b1110};
      4'hD: key_map = {4'b0111, 4'b1101};
      4'hE: key_map = {4'b0111, 4'b1011};
      default: key_map = {4'b0111, 4'b0111};
    endcase
  endfunction

  // Ready is withheld while full, even if a pop happens the same cycle.
  assign cmd_ready = !reset && (count_q != CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  // Column return: the only combinational row-to-column path.
  always_comb begin
    rowcol    = key_map(key_q);
    keypadCol = 4'b1111;
    if (active_q && (keypadRow == rowcol[7:4])) keypadCol = rowcol[3:0];
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) wr_d = wr_q + AW'(1);
    if (pop)  rd_d = rd_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk_div) begin
    if (push) mem_q[wr_q] <= cmd_key;
  end

  // FIFO control registers.
  always_ff @(posedge clk_div) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Press/gap sequencer next-state and outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    key_d    = key_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          key_d    = mem_q[rd_q];
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == 8'(HOLD_CYCLES - 1)) begin
          active_d = 1'b0;
          cnt_d    = '0;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'(GAP_CYCLES - 1)) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_div) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= 1'b0;
      key_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      key_q    <= key_d;
      done_q   <= done_d;
    end
  end

  assign key_active  = active_q;
  assign pressed_key = key_q;
  assign key_done    = done_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: queue/timeline reference model plus directed scenarios.
module tb_keypad_emulator;
  localparam int HOLD  = 24;
  localparam int GAP   = 12;
  localparam int DEPTH = 4;

  logic       clk_div = 1'b0;
  logic       reset, cmd_valid, cmd_ready, key_active, key_done;
  logic [3:0] keypadRow, cmd_key, keypadCol, pressed_key;
  logic [2:0] fifo_count;

  always #5 clk_div = ~clk_div;

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_div(clk_div), .reset(reset), .keypadRow(keypadRow),
    .cmd_valid(cmd_valid), .cmd_key(cmd_key), .cmd_ready(cmd_ready),
    .keypadCol(keypadCol), .key_active(key_active), .pressed_key(pressed_key),
    .key_done(key_done), .fifo_count(fifo_count)
  );

  // Physical layout: kmap[row index][col index], row/col index i means bit i low.
  logic [3:0] kmap [4][4] = '{'{4'h7, 4'h4, 4'h1, 4'h0},
                              '{4'h8, 4'h5, 4'h2, 4'hA},
                              '{4'h9, 4'h6, 4'h3, 4'hB},
                              '{4'hC, 4'hD, 4'hE, 4'hF}};

  int errors = 0;
  int checks = 0;

  // Reference model: queue of pending keys and the start edge of the current press.
  logic [3:0] mq[$];
  int         cyc = 0;
  bit         seq_v = 0;
  int         seq_s = 0;
  int         free_at = 0;
  logic [3:0] m_pk = 4'h0;

  // Observation bookkeeping.
  logic [3:0] st_key[$];
  int         st_cyc[$];
  bit         prev_act = 0;
  int         act_cnt = 0, done_cnt = 0, last_done = 0;
  bit         seen1101 = 0, bad_col = 0;
  bit         scan_en = 1, scan_hit = 0;
  int         scan_ph = 0, ridx = 0, scan_cyc = 0;
  logic [3:0] scan_key = 4'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit m_active();
    return seq_v && (cyc < seq_s + HOLD);
  endfunction

  function automatic bit m_done();
    return seq_v && (cyc == seq_s + HOLD + GAP);
  endfunction

  function automatic logic [3:0] m_col();
    logic [3:0] rp, cp;
    m_col = 4'hF;
    if (m_active())
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (kmap[r][c] == m_pk) begin
            rp = ~4'(1 << r);
            cp = ~4'(1 << c);
            if (keypadRow == rp) m_col = cp;
          end
  endfunction

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    int sz = mq.size();
    bit do_push = !reset && cmd_valid && (sz != DEPTH);
    cyc++;
    if (reset) begin
      mq.delete();
      seq_v   = 0;
      free_at = 0;
      m_pk    = 4'h0;
    end else begin
      if (sz > 0 && cyc >= free_at) begin
        m_pk    = mq.pop_front();
        seq_v   = 1;
        seq_s   = cyc;
        free_at = cyc + HOLD + GAP + 1;
      end
      if (do_push) mq.push_back(cmd_key);
    end
  endtask

  task automatic check_all();
    chk("key_active",  key_active,  m_active());
    chk("key_done",    key_done,    m_done());
    chk("pressed_key", pressed_key, m_pk);
    chk("fifo_count",  fifo_count,  mq.size());
    chk("cmd_ready",   cmd_ready,   !reset && (mq.size() != DEPTH));
    chk("keypadCol",   keypadCol,   m_col());
  endtask

  task automatic step();
    logic [3:0] rp, cp;
    @(posedge clk_div);
    model_edge();
    #1;
    check_all();
    if (key_active === 1'b1 && !prev_act) begin
      st_key.push_back(pressed_key);
      st_cyc.push_back(cyc);
    end
    prev_act = (key_active === 1'b1);
    if (key_active === 1'b1) act_cnt++;
    if (key_done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
    if (keypadRow == 4'hD && keypadCol == 4'hD) seen1101 = 1;
    if (pressed_key == 4'h5 && keypadRow != 4'hD && keypadCol != 4'hF) bad_col = 1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rp = ~4'(1 << r);
        cp = ~4'(1 << c);
        if (keypadRow == rp && keypadCol == cp && !scan_hit) begin
          scan_hit = 1;
          scan_key = kmap[r][c];
          scan_cyc = cyc;
        end
      end
    if (scan_en) begin
      scan_ph++;
      if (scan_ph == 3) begin
        scan_ph = 0;
        ridx = (ridx + 1) % 4;
      end
      keypadRow = ~4'(1 << ridx);
    end
  endtask

  task automatic push(input logic [3:0] k);
    cmd_key   = k;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic rowchk(input string name, input logic [3:0] row, input logic [3:0] exp);
    keypadRow = row;
    #1;
    chk(name, keypadCol, exp);
  endtask

  function automatic logic [3:0] skey(input int i);
    return (i < st_key.size()) ? st_key[i] : 4'hX;
  endfunction

  function automatic int scyc(input int i);
    return (i < st_cyc.size()) ? st_cyc[i] : -1000;
  endfunction

  initial begin
    int base, n0, guard, acc6, sdone, sst;
    bit acc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_key = 4'h0; keypadRow = 4'hF;

    // Reset state
    step(); step();
    chk("rst_active", key_active, 0);
    chk("rst_col",    keypadCol, 4'hF);
    chk("rst_ready",  cmd_ready, 0);
    chk("rst_count",  fifo_count, 0);
    chk("rst_pk",     pressed_key, 0);
    chk("rst_done",   key_done, 0);
    reset = 1'b0;
    step();

    // Single key 5 with scanning rows
    act_cnt = 0; done_cnt = 0;
    push(4'h5);
    chk("t1_not_yet", key_active, 0);
    chk("t1_count",   fifo_count, 1);
    step();
    chk("t1_rise", key_active, 1);
    chk("t1_pk",   pressed_key, 4'h5);
    for (int i = 0; i < 45; i++) step();
    chk("t1_hold_cycles", act_cnt, 24);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_done_offset", last_done - scyc(0), 36);
    chk("t1_col_row1101", seen1101, 1);
    chk("t1_col_other",   bad_col, 0);
    chk("t1_pk_held",     pressed_key, 4'h5);

    // Three queued keys, 37-cycle period
    push(4'h0); push(4'hF); push(4'hA);
    for (int i = 0; i < 130; i++) step();
    chk("t2_key0", skey(1), 4'h0);
    chk("t2_keyF", skey(2), 4'hF);
    chk("t2_keyA", skey(3), 4'hA);
    chk("t2_period1", scyc(2) - scyc(1), 37);
    chk("t2_period2", scyc(3) - scyc(2), 37);

    // Fill the FIFO with held valid
    base = st_key.size();
    acc6 = 0;
    for (int k = 1; k <= 6; k++) begin
      cmd_key = 4'(k);
      cmd_valid = 1'b1;
      guard = 0;
      do begin
        acc = cmd_ready;
        step();
        guard++;
      end while (!acc && guard < 100);
      if (!acc) chk("t3_accept_timeout", 0, 1);
      if (k == 5) begin
        chk("t3_full_count", fifo_count, 4);
        chk("t3_full_ready", cmd_ready, 0);
      end
      if (k == 6) acc6 = cyc;
    end
    cmd_valid = 1'b0;
    chk("t3_key6_accept", acc6 - scyc(base), 38);
    for (int i = 0; i < 230; i++) step();
    for (int k = 0; k < 6; k++) chk("t3_order", skey(base + k), 4'(k + 1));

    // Reset during PRESS with entries queued
    push(4'h9);
    step();
    chk("t4_active", key_active, 1);
    cmd_key = 4'h1; cmd_valid = 1'b1; step();
    cmd_key = 4'h2; step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("t4_pre_count", fifo_count, 2);
    reset = 1'b1;
    step();
    chk("t4_col",    keypadCol, 4'hF);
    chk("t4_active_off", key_active, 0);
    chk("t4_count",  fifo_count, 0);
    reset = 1'b0;
    #1;
    chk("t4_ready", cmd_ready, 1);
    sdone = done_cnt; sst = st_key.size();
    for (int i = 0; i < 60; i++) step();
    chk("t4_no_done",  done_cnt, sdone);
    chk("t4_no_start", st_key.size(), sst);

    // Malformed row strobes on key 3
    scan_en = 0;
    keypadRow = 4'hF;
    push(4'h3);
    step();
    chk("t5_active", key_active, 1);
    rowchk("t5_row1111", 4'b1111, 4'hF);
    rowchk("t5_row0000", 4'b0000, 4'hF);
    rowchk("t5_row1001", 4'b1001, 4'hF);
    rowchk("t5_row1011", 4'b1011, 4'b1011);
    rowchk("t5_row1110", 4'b1110, 4'hF);
    keypadRow = 4'hF;
    for (int i = 0; i < 50; i++) step();

    // Closed loop with a 3-cycles/row scanner: keys 4 then 7
    scan_en = 1; scan_ph = 0; ridx = 0; keypadRow = 4'b1110;
    scan_hit = 0;
    n0 = st_key.size();
    push(4'h4); push(4'h7);
    guard = 0;
    while (st_key.size() <= n0 && guard < 40) begin step(); guard++; end
    guard = 0;
    while (!scan_hit && guard < 12) begin step(); guard++; end
    chk("t6_hit4", scan_hit, 1);
    chk("t6_key4", scan_key, 4'h4);
    chk("t6_lat4", (scan_cyc - scyc(n0)) <= 12, 1);
    guard = 0;
    while (key_active && guard < 40) begin step(); guard++; end
    scan_hit = 0;
    guard = 0;
    while (st_key.size() <= n0 + 1 && guard < 40) begin step(); guard++; end
    guard = 0;
    while (!scan_hit && guard < 12) begin step(); guard++; end
    chk("t6_hit7", scan_hit, 1);
    chk("t6_key7", scan_key, 4'h7);
    chk("t6_lat7", (scan_cyc - scyc(n0 + 1)) <= 12, 1);
    for (int i = 0; i < 50; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
